// File: rtl/orv64_typedef_pkg.sv
// -----------------------------------------------------------------------------
// orv64_typedef_pkg
// Shared ORV64 types used by the memory-breakpoint control path:
//   - orv64_vaddr_t        : virtual address carried on the EX->DC request
//   - orv64_bp_mem_cfg_t   : per-slot breakpoint match configuration
//   - orv64_mem_bp_state_e : breakpoint control FSM states
//   - ORV64_MEM_BP_REG_*   : debug register indices of the breakpoint block
//   - ORV64_MEM_BP_STS_*   : bit positions inside the status register
//   - ORV64_MEM_BP_CTRL_*  : bit positions inside the control register
// -----------------------------------------------------------------------------
package orv64_typedef_pkg;

    localparam int ORV64_VADDR_W = 39;
    typedef logic [ORV64_VADDR_W-1:0] orv64_vaddr_t;

    // DISABLE matches no access at all, so it is the safe reset value.
    typedef enum logic [1:0] {
        ORV64_BP_DISABLE = 2'b00,
        ORV64_BP_READ    = 2'b01,
        ORV64_BP_WRITE   = 2'b10,
        ORV64_BP_RW      = 2'b11
    } orv64_bp_mem_cfg_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HALTED   = 2'd1,
        RESUMING = 2'd2
    } orv64_mem_bp_state_e;

    localparam logic [3:0] ORV64_MEM_BP_REG_ADDR0    = 4'd0;
    localparam logic [3:0] ORV64_MEM_BP_REG_CFG0     = 4'd4;
    localparam logic [3:0] ORV64_MEM_BP_REG_STATUS   = 4'd8;
    localparam logic [3:0] ORV64_MEM_BP_REG_HIT_ADDR = 4'd9;
    localparam logic [3:0] ORV64_MEM_BP_REG_CTRL     = 4'd10;
    localparam logic [3:0] ORV64_MEM_BP_REG_HIT_CNT  = 4'd11;

    localparam int ORV64_MEM_BP_STS_STATE_LSB = 0;
    localparam int ORV64_MEM_BP_STS_STATE_MSB = 1;
    localparam int ORV64_MEM_BP_STS_HIT_WE    = 2;
    localparam int ORV64_MEM_BP_STS_HIT_RE    = 3;
    localparam int ORV64_MEM_BP_STS_ABORT     = 4;

    localparam int ORV64_MEM_BP_CTRL_RESUME = 0;
    localparam int ORV64_MEM_BP_CTRL_CLEAR  = 1;

    // Zero-extend a virtual address onto the 64-bit debug data bus.
    function automatic logic [63:0] orv64_vaddr_zext(input orv64_vaddr_t a);
        return {{(64-ORV64_VADDR_W){1'b0}}, a};
    endfunction

endpackage

// File: rtl/orv64_mem_bp_regfile.sv
// -----------------------------------------------------------------------------
// orv64_mem_bp_regfile
// Debug-side register file of the memory-breakpoint block: decodes the
// single-outstanding cfg request bus, stores the breakpoint addresses and
// configs, and holds the response until the debugger consumes it.
// Ports:
//   clk_i, rstn_i                 clock, async active-low reset
//   req_*_i / req_ready_o         request channel (valid/ready)
//   resp_valid_o / resp_ready_i   response channel, resp_rdata_o read data
//   status_i, hit_addr_i,
//   hit_cnt_i                     read-only values owned by the control FSM
//   bp_addr_o, bp_cfg_o           per-slot breakpoint registers
//   ctrl_resume_o, ctrl_clear_o   one-cycle pulses from a control write
// -----------------------------------------------------------------------------
module orv64_mem_bp_regfile
    import orv64_typedef_pkg::*;
#(
    parameter int NUM_BP = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [3:0]        req_idx_i,
    input  logic [63:0]       req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [63:0]       resp_rdata_o,
    input  logic [63:0]       status_i,
    input  logic [63:0]       hit_addr_i,
    input  logic [63:0]       hit_cnt_i,
    output orv64_vaddr_t      bp_addr_o [NUM_BP],
    output orv64_bp_mem_cfg_t bp_cfg_o  [NUM_BP],
    output logic              ctrl_resume_o,
    output logic              ctrl_clear_o
);

    orv64_vaddr_t      addr_q [NUM_BP];
    orv64_vaddr_t      addr_d [NUM_BP];
    orv64_bp_mem_cfg_t cfg_q  [NUM_BP];
    orv64_bp_mem_cfg_t cfg_d  [NUM_BP];
    logic              resp_valid_q, resp_valid_d;
    logic [63:0]       resp_rdata_q, resp_rdata_d;
    logic [63:0]       rdata_s;
    logic              accept_s;
    logic              wr_s;
    logic              ctrl_wr_s;
    logic              unused_wdata_s;

    // A new request may enter whenever the response slot is empty or draining.
    assign req_ready_o    = ~resp_valid_q | resp_ready_i;
    assign accept_s       = req_valid_i & req_ready_o;
    assign wr_s           = accept_s & req_we_i;
    assign ctrl_wr_s      = wr_s & (req_idx_i == ORV64_MEM_BP_REG_CTRL);
    assign ctrl_resume_o  = ctrl_wr_s & req_wdata_i[ORV64_MEM_BP_CTRL_RESUME];
    assign ctrl_clear_o   = ctrl_wr_s & req_wdata_i[ORV64_MEM_BP_CTRL_CLEAR];
    assign unused_wdata_s = ^req_wdata_i[63:ORV64_VADDR_W];

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign bp_addr_o    = addr_q;
    assign bp_cfg_o     = cfg_q;

    // Breakpoint register write decode: idx[3:2] selects bank, idx[1:0] slot.
    always_comb begin
        addr_d = addr_q;
        cfg_d  = cfg_q;
        case ({wr_s, req_idx_i[3:2]})
            3'b100:  addr_d[req_idx_i[1:0]] = req_wdata_i[ORV64_VADDR_W-1:0];
            3'b101:  cfg_d[req_idx_i[1:0]]  = orv64_bp_mem_cfg_t'(req_wdata_i[1:0]);
            default: ;
        endcase
    end

    // Read data mux; unmapped and write-only indices read as zero.
    always_comb begin
        rdata_s = 64'd0;
        case (req_idx_i[3:2])
            2'b00: rdata_s = orv64_vaddr_zext(addr_q[req_idx_i[1:0]]);
            2'b01: rdata_s = {62'd0, cfg_q[req_idx_i[1:0]]};
            2'b10: begin
                case (req_idx_i)
                    ORV64_MEM_BP_REG_STATUS:   rdata_s = status_i;
                    ORV64_MEM_BP_REG_HIT_ADDR: rdata_s = hit_addr_i;
                    ORV64_MEM_BP_REG_HIT_CNT:  rdata_s = hit_cnt_i;
                    default:                   rdata_s = 64'd0;
                endcase
            end
            default: rdata_s = 64'd0;
        endcase
    end

    // Response slot: loaded on acceptance, held until consumed.
    always_comb begin
        resp_rdata_d = resp_rdata_q;
        if (accept_s) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = req_we_i ? 64'd0 : rdata_s;
        end else begin
            resp_valid_d = resp_valid_q & ~resp_ready_i;
        end
    end

    // Register state; reset leaves every slot disabled at address zero.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q       <= '{default: '0};
            cfg_q        <= '{default: ORV64_BP_DISABLE};
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
        end else begin
            addr_q       <= addr_d;
            cfg_q        <= cfg_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

endmodule

// File: rtl/orv64_mem_bp_ctrl.sv
// -----------------------------------------------------------------------------
// orv64_mem_bp_ctrl
// Control end of the memory-breakpoint path (EX->DC). Owns the breakpoint
// registers (via orv64_mem_bp_regfile), halts the hart when the comparator
// stalls an access, records the hit, and sequences debug_resume so the
// stalled access passes exactly once after the debugger resumes.
// Optional feature: define ORV64_MEM_BP_HIT_CNT_EN to add a CNT_W-bit
// saturating hit counter at register index 11 (reads 0 otherwise).
// Ports:
//   clk, rstn                      clock, async active-low reset
//   cfg_req_* / cfg_resp_*         debug register access bus
//   bp_mem_addr_0..3, bp_mem_cfg_0..3  breakpoint registers to comparator
//   mem_bp_stall_in                comparator hit/stall indication
//   ex_addr, ex_we, ex_re          EX->DC request being stalled
//   debug_resume                   releases the stalled access
//   bp_halt_req, bp_halted         halt request / halted indication
// -----------------------------------------------------------------------------
module orv64_mem_bp_ctrl
    import orv64_typedef_pkg::*;
#(
    parameter int NUM_BP = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_req_valid,
    output logic              cfg_req_ready,
    input  logic              cfg_req_we,
    input  logic [3:0]        cfg_req_idx,
    input  logic [63:0]       cfg_req_wdata,
    output logic              cfg_resp_valid,
    input  logic              cfg_resp_ready,
    output logic [63:0]       cfg_resp_rdata,
    output orv64_vaddr_t      bp_mem_addr_0,
    output orv64_vaddr_t      bp_mem_addr_1,
    output orv64_vaddr_t      bp_mem_addr_2,
    output orv64_vaddr_t      bp_mem_addr_3,
    output orv64_bp_mem_cfg_t bp_mem_cfg_0,
    output orv64_bp_mem_cfg_t bp_mem_cfg_1,
    output orv64_bp_mem_cfg_t bp_mem_cfg_2,
    output orv64_bp_mem_cfg_t bp_mem_cfg_3,
    input  logic              mem_bp_stall_in,
    input  orv64_vaddr_t      ex_addr,
    input  logic              ex_we,
    input  logic              ex_re,
    output logic              debug_resume,
    output logic              bp_halt_req,
    output logic              bp_halted
);

    orv64_mem_bp_state_e state_q, state_d;
    orv64_vaddr_t        hit_addr_q, hit_addr_d;
    logic                hit_we_q, hit_we_d;
    logic                hit_re_q, hit_re_d;
    logic                abort_q, abort_d;
    logic                halt_req_q, halt_req_d;
    logic                resume_q, resume_d;
    logic                hit_s;
    logic                ctrl_resume_s;
    logic                ctrl_clear_s;
    logic [63:0]         status_s;
    logic [63:0]         hit_cnt_s;
    orv64_vaddr_t        bp_addr_s [NUM_BP];
    orv64_bp_mem_cfg_t   bp_cfg_s  [NUM_BP];

    orv64_mem_bp_regfile #(.NUM_BP(NUM_BP)) u_regfile (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .req_valid_i   (cfg_req_valid),
        .req_ready_o   (cfg_req_ready),
        .req_we_i      (cfg_req_we),
        .req_idx_i     (cfg_req_idx),
        .req_wdata_i   (cfg_req_wdata),
        .resp_valid_o  (cfg_resp_valid),
        .resp_ready_i  (cfg_resp_ready),
        .resp_rdata_o  (cfg_resp_rdata),
        .status_i      (status_s),
        .hit_addr_i    (orv64_vaddr_zext(hit_addr_q)),
        .hit_cnt_i     (hit_cnt_s),
        .bp_addr_o     (bp_addr_s),
        .bp_cfg_o      (bp_cfg_s),
        .ctrl_resume_o (ctrl_resume_s),
        .ctrl_clear_o  (ctrl_clear_s)
    );

    assign bp_mem_addr_0 = bp_addr_s[0];
    assign bp_mem_addr_1 = bp_addr_s[1];
    assign bp_mem_addr_2 = bp_addr_s[2];
    assign bp_mem_addr_3 = bp_addr_s[3];
    assign bp_mem_cfg_0  = bp_cfg_s[0];
    assign bp_mem_cfg_1  = bp_cfg_s[1];
    assign bp_mem_cfg_2  = bp_cfg_s[2];
    assign bp_mem_cfg_3  = bp_cfg_s[3];

    assign bp_halt_req  = halt_req_q;
    assign bp_halted    = halt_req_q;
    assign debug_resume = resume_q;

    // Status word assembled from the FSM state and recorded hit information.
    always_comb begin
        status_s = 64'd0;
        status_s[ORV64_MEM_BP_STS_STATE_MSB:ORV64_MEM_BP_STS_STATE_LSB] = state_q;
        status_s[ORV64_MEM_BP_STS_HIT_WE] = hit_we_q;
        status_s[ORV64_MEM_BP_STS_HIT_RE] = hit_re_q;
        status_s[ORV64_MEM_BP_STS_ABORT]  = abort_q;
    end

    // Next state and hit capture. Clear is applied first so that a hit or a
    // flush in the same cycle overrides it.
    always_comb begin
        state_d    = state_q;
        hit_s      = 1'b0;
        hit_addr_d = ctrl_clear_s ? '0   : hit_addr_q;
        hit_we_d   = ctrl_clear_s ? 1'b0 : hit_we_q;
        hit_re_d   = ctrl_clear_s ? 1'b0 : hit_re_q;
        abort_d    = ctrl_clear_s ? 1'b0 : abort_q;
        case (state_q)
            IDLE: begin
                if (mem_bp_stall_in) begin
                    hit_s      = 1'b1;
                    hit_addr_d = ex_addr;
                    hit_we_d   = ex_we;
                    hit_re_d   = ex_re;
                    state_d    = HALTED;
                end else begin
                    state_d = IDLE;
                end
            end
            HALTED: begin
                // A flushed access cannot be resumed, so flush wins over resume.
                if (!mem_bp_stall_in) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (ctrl_resume_s) begin
                    state_d = RESUMING;
                end else begin
                    state_d = HALTED;
                end
            end
            RESUMING: begin
                // Stay while downstream backpressure keeps the access stalled.
                if (!mem_bp_stall_in) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESUMING;
                end
            end
            default: state_d = IDLE;
        endcase
        halt_req_d = (state_d == HALTED);
        resume_d   = (state_d == RESUMING);
    end

    // FSM state, hit record and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            hit_addr_q <= '0;
            hit_we_q   <= 1'b0;
            hit_re_q   <= 1'b0;
            abort_q    <= 1'b0;
            halt_req_q <= 1'b0;
            resume_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hit_addr_q <= hit_addr_d;
            hit_we_q   <= hit_we_d;
            hit_re_q   <= hit_re_d;
            abort_q    <= abort_d;
            halt_req_q <= halt_req_d;
            resume_q   <= resume_d;
        end
    end

`ifdef ORV64_MEM_BP_HIT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base_s;

    // Saturating hit counter; a hit in the clearing cycle counts from zero.
    always_comb begin
        cnt_base_s = ctrl_clear_s ? '0 : cnt_q;
        if (hit_s && (cnt_base_s != {CNT_W{1'b1}})) begin
            cnt_d = cnt_base_s + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_base_s;
        end
    end

    // Hit counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt_s = {{(64-CNT_W){1'b0}}, cnt_q};
`else
    assign hit_cnt_s = 64'd0;
`endif

endmodule

// File: tb/tb_orv64_mem_bp_ctrl.sv
module tb_orv64_mem_bp_ctrl;
    import orv64_typedef_pkg::*;

    // Small counter width so saturation is reachable in a short run.
    localparam int TB_CNT_W = 6;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef ORV64_MEM_BP_HIT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    localparam logic [63:0] VMASK = (64'd1 << ORV64_VADDR_W) - 64'd1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic cfg_req_valid = 1'b0, cfg_req_we = 1'b0, cfg_resp_ready = 1'b1;
    logic [3:0] cfg_req_idx = 4'd0;
    logic [63:0] cfg_req_wdata = 64'd0;
    logic stall = 1'b0, ex_we = 1'b0, ex_re = 1'b0;
    orv64_vaddr_t ex_addr = '0;
    logic cfg_req_ready, cfg_resp_valid, debug_resume, bp_halt_req, bp_halted;
    logic [63:0] cfg_resp_rdata;
    orv64_vaddr_t a0, a1, a2, a3;
    orv64_bp_mem_cfg_t c0, c1, c2, c3;
    logic [63:0] dut_addr [4];
    logic [1:0]  dut_cfg  [4];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_halted, m_resuming, m_rv, m_hit_we, m_hit_re, m_abort;
    logic [63:0] m_hit_addr;
    int m_cnt;
    logic [63:0] m_addr [4];
    logic [1:0]  m_cfg  [4];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    orv64_mem_bp_ctrl #(.NUM_BP(4), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_req_valid(cfg_req_valid), .cfg_req_ready(cfg_req_ready),
        .cfg_req_we(cfg_req_we), .cfg_req_idx(cfg_req_idx), .cfg_req_wdata(cfg_req_wdata),
        .cfg_resp_valid(cfg_resp_valid), .cfg_resp_ready(cfg_resp_ready),
        .cfg_resp_rdata(cfg_resp_rdata),
        .bp_mem_addr_0(a0), .bp_mem_addr_1(a1), .bp_mem_addr_2(a2), .bp_mem_addr_3(a3),
        .bp_mem_cfg_0(c0), .bp_mem_cfg_1(c1), .bp_mem_cfg_2(c2), .bp_mem_cfg_3(c3),
        .mem_bp_stall_in(stall), .ex_addr(ex_addr), .ex_we(ex_we), .ex_re(ex_re),
        .debug_resume(debug_resume), .bp_halt_req(bp_halt_req), .bp_halted(bp_halted)
    );

    assign dut_addr[0] = orv64_vaddr_zext(a0);
    assign dut_addr[1] = orv64_vaddr_zext(a1);
    assign dut_addr[2] = orv64_vaddr_zext(a2);
    assign dut_addr[3] = orv64_vaddr_zext(a3);
    assign dut_cfg[0] = c0;
    assign dut_cfg[1] = c1;
    assign dut_cfg[2] = c2;
    assign dut_cfg[3] = c3;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 1'b0; m_resuming = 1'b0; m_rv = 1'b0;
        m_hit_we = 1'b0; m_hit_re = 1'b0; m_abort = 1'b0;
        m_hit_addr = 64'd0; m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = 64'd0;
            m_cfg[i]  = 2'b00;
        end
        exp_q.delete();
    endtask

    // Advance the model by one clock using the inputs the DUT will sample.
    task automatic model_step();
        bit acc, wr, resume, clr;
        logic [63:0] rd;
        logic [1:0] code;
        int idx;
        idx    = int'(cfg_req_idx);
        acc    = cfg_req_valid && (!m_rv || cfg_resp_ready);
        wr     = acc && cfg_req_we;
        resume = wr && (idx == 10) && cfg_req_wdata[0];
        clr    = wr && (idx == 10) && cfg_req_wdata[1];
        code   = m_halted ? 2'd1 : (m_resuming ? 2'd2 : 2'd0);
        if (acc) begin
            rd = 64'd0;
            if (!cfg_req_we) begin
                if (idx < 4)        rd = m_addr[idx];
                else if (idx < 8)   rd = {62'd0, m_cfg[idx-4]};
                else if (idx == 8)  rd = {59'd0, m_abort, m_hit_re, m_hit_we, code};
                else if (idx == 9)  rd = m_hit_addr;
                else if (idx == 11) rd = CNT_ON ? 64'(m_cnt) : 64'd0;
            end
            exp_q.push_back(rd);
            m_rv = 1'b1;
        end else if (cfg_resp_ready) begin
            m_rv = 1'b0;
        end
        if (wr && idx < 4)      m_addr[idx]   = cfg_req_wdata & VMASK;
        else if (wr && idx < 8) m_cfg[idx-4] = cfg_req_wdata[1:0];
        if (clr) begin
            m_hit_addr = 64'd0; m_hit_we = 1'b0; m_hit_re = 1'b0; m_abort = 1'b0; m_cnt = 0;
        end
        if (!m_halted && !m_resuming) begin
            if (stall) begin
                m_hit_addr = orv64_vaddr_zext(ex_addr);
                m_hit_we = ex_we; m_hit_re = ex_re;
                if (m_cnt < CNT_MAX) m_cnt++;
                m_halted = 1'b1;
            end
        end else if (m_halted) begin
            if (!stall) begin
                m_halted = 1'b0; m_abort = 1'b1;
            end else if (resume) begin
                m_halted = 1'b0; m_resuming = 1'b1;
            end
        end else if (!stall) begin
            m_resuming = 1'b0;
        end
    endtask

    // Model: compare the registered outputs, then step with this cycle's inputs.
    always @(negedge clk) begin
        if (!rstn) begin
            model_reset();
        end else begin
            check("ctrl_outputs",
                  {59'd0, bp_halt_req, bp_halted, debug_resume, cfg_resp_valid, cfg_req_ready},
                  {59'd0, m_halted, m_halted, m_resuming, m_rv, (!m_rv || cfg_resp_ready)});
            for (int i = 0; i < 4; i++) begin
                check("bp_addr", dut_addr[i], m_addr[i]);
                check("bp_cfg", {62'd0, dut_cfg[i]}, {62'd0, m_cfg[i]});
            end
            model_step();
        end
    end

    // Monitor: pop the scoreboard whenever a response is consumed.
    always @(negedge clk) begin
        if (rstn && cfg_resp_valid && cfg_resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 64'd1, 64'd0);
            end else begin
                check("resp_rdata", cfg_resp_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic cfg_op(input bit we, input logic [3:0] idx, input logic [63:0] d);
        cfg_req_valid = 1'b1; cfg_req_we = we; cfg_req_idx = idx; cfg_req_wdata = d;
        step();
        cfg_req_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] r64;
        step(); step();
        rstn = 1'b1;
        check("rst_halt", {62'd0, bp_halt_req, debug_resume}, 64'd0);
        check("rst_cfg0", {62'd0, c0}, {62'd0, ORV64_BP_DISABLE});
        for (int i = 4; i < 8; i++) cfg_op(1'b0, 4'(i), 64'd0);
        cfg_op(1'b1, 4'd0, 64'h8000_1000);
        cfg_op(1'b1, 4'd4, 64'd1);
        cfg_op(1'b0, 4'd0, 64'd0);
        cfg_op(1'b0, 4'd4, 64'd0);
        step();
        // Response backpressure: request channel blocked while slot is full.
        cfg_resp_ready = 1'b0;
        cfg_op(1'b0, 4'd0, 64'd0);
        cfg_req_valid = 1'b1; cfg_req_idx = 4'd4;
        for (int i = 0; i < 3; i++) begin
            step();
            check("req_ready_bp", {63'd0, cfg_req_ready}, 64'd0);
        end
        cfg_resp_ready = 1'b1;
        step();
        cfg_req_valid = 1'b0;
        step();
        // Hit, inspect, resume with downstream backpressure.
        stall = 1'b1; ex_addr = 39'h80_0000_1000 & 39'h7F_FFFF_FFFF; ex_addr = 39'h0_8000_1000; ex_re = 1'b1; ex_we = 1'b0;
        step();
        check("halt_after_hit", {62'd0, bp_halt_req, bp_halted}, 64'd3);
        cfg_op(1'b0, 4'd8, 64'd0);
        cfg_op(1'b0, 4'd9, 64'd0);
        cfg_op(1'b0, 4'd11, 64'd0);
        cfg_op(1'b1, 4'd10, 64'd1);
        step(); step();
        stall = 1'b0;
        step(); step();
        // Flush without resume, then flush together with resume.
        stall = 1'b1; step();
        stall = 1'b0; step();
        cfg_op(1'b0, 4'd8, 64'd0);
        stall = 1'b1; step();
        stall = 1'b0; cfg_op(1'b1, 4'd10, 64'd1);
        cfg_op(1'b0, 4'd8, 64'd0);
        // Saturate the counter, then clear and hit in the same cycle.
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            stall = 1'b1; step();
            stall = 1'b0; step();
        end
        cfg_op(1'b0, 4'd11, 64'd0);
        stall = 1'b1; cfg_op(1'b1, 4'd10, 64'd2);
        stall = 1'b0; step();
        cfg_op(1'b0, 4'd11, 64'd0);
        cfg_op(1'b0, 4'd8, 64'd0);
        // Asynchronous reset while resuming.
        cfg_op(1'b1, 4'd5, 64'd3);
        stall = 1'b1; step();
        cfg_op(1'b1, 4'd10, 64'd1);
        step();
        rstn = 1'b0;
        #1;
        check("arst_outputs",
              {60'd0, debug_resume, bp_halt_req, bp_halted, cfg_resp_valid}, 64'd0);
        check("arst_cfg1", {62'd0, c1}, {62'd0, ORV64_BP_DISABLE});
        stall = 1'b0;
        step(); step();
        rstn = 1'b1;
        step();
        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 30) stall = ~stall;
            r64 = {$urandom, $urandom};
            ex_addr = r64[ORV64_VADDR_W-1:0];
            ex_we = 1'($urandom_range(0, 1));
            ex_re = 1'($urandom_range(0, 1));
            cfg_req_valid = ($urandom_range(0, 99) < 50);
            cfg_req_we = 1'($urandom_range(0, 1));
            cfg_req_idx = ($urandom_range(0, 99) < 40) ? 4'd10 : 4'($urandom_range(0, 15));
            cfg_req_wdata = {$urandom, $urandom};
            if (cfg_req_idx == 4'd10) cfg_req_wdata = {62'd0, 2'($urandom_range(0, 3))};
            cfg_resp_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        cfg_req_valid = 1'b0; cfg_resp_ready = 1'b1; stall = 1'b0;
        step(); step(); step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/orv64_mem_bp_ctrl.md
Name: orv64_mem_bp_ctrl

Overview:
- Control end of the ORV64 memory-breakpoint path, placed between the debug module and the memory-breakpoint comparator in the EX→DC stage.
- Holds the four breakpoint address/config registers and drives them to the comparator.
- Watches the comparator's stall indication, halts the hart, and records hit information.
- Sequences `debug_resume` so a stalled access can pass exactly once after the debugger resumes.

Parameters:
- NUM_BP, 4, number of breakpoint slots (fixed to 4; comparator ports are per-slot).
- CNT_W, 16, width of the saturating hit counter.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- cfg_req_valid  in  1  debug register-access request
- cfg_req_ready  out  1  request accepted when valid&ready
- cfg_req_we  in  1  1=write, 0=read
- cfg_req_idx  in  4  register index (map below)
- cfg_req_wdata  in  64  write data
- cfg_resp_valid  out  1  response valid
- cfg_resp_ready  in  1  response consumed when valid&ready
- cfg_resp_rdata  out  64  read data (0 for writes)
- bp_mem_addr_0..3  out  orv64_vaddr_t  breakpoint addresses to comparator
- bp_mem_cfg_0..3  out  orv64_bp_mem_cfg_t  breakpoint configs to comparator
- mem_bp_stall_in  in  1  comparator hit/stall (valid request matching an enabled slot)
- ex_addr  in  orv64_vaddr_t  EX→DC request address
- ex_we, ex_re  in  1  EX→DC request type
- debug_resume  out  1  to comparator; releases the stalled access
- bp_halt_req  out  1  halt request to debug module
- bp_halted  out  1  FSM in HALTED

Behaviour:
- Reset values: all addr regs 0; all cfg regs ORV64_BP_DISABLE (2'b00, matches no access); FSM IDLE; outputs 0; status, hit regs and counter 0.
- Register map:
  - 0–3: bp addr 0–3 (RW, low VADDR bits).
  - 4–7: bp cfg 0–3 (RW, bits[1:0]).
  - 8: status (RO): [1:0] state, [2] hit_we, [3] hit_re, [4] abort sticky.
  - 9: hit addr (RO).
  - 10: control (WO): bit0 resume, bit1 clear abort/hit regs.
  - 11: hit counter (RO).
  - Others: read 0, writes ignored.
- Config handshake:
  - One outstanding request.
  - cfg_req_ready = ~cfg_resp_valid | cfg_resp_ready.
  - cfg_resp_valid is asserted the cycle after acceptance and held until consumed.
  - Writes update the register on the acceptance edge; the comparator sees the new value the next cycle.
  - Writes are allowed in any state.
- FSM:
  - IDLE:
    - On mem_bp_stall_in: latch ex_addr, ex_we, ex_re into the hit regs; increment the counter (saturating at all-ones).
    - Go to HALTED; bp_halt_req=1 from the next cycle.
  - HALTED:
    - bp_halt_req=1.
    - Resume write: go to RESUMING; debug_resume=1 from the next cycle.
    - mem_bp_stall_in=0 (request flushed) with no resume: go to IDLE; set abort sticky; drop bp_halt_req.
    - Resume and flush in the same cycle: flush wins (IDLE, abort set).
  - RESUMING:
    - debug_resume=1, bp_halt_req=0.
    - Stay while mem_bp_stall_in=1, i.e. the access is held by downstream backpressure.
    - First cycle mem_bp_stall_in=0: go to IDLE; debug_resume=0 the next cycle.
    - A new hit can only be recognised from IDLE, so a back-to-back access to the same address halts again one cycle after the resumed access leaves.
  - Resume write in IDLE or RESUMING: ignored.
- Clear (control bit1): zeroes hit addr, hit_we/re, abort and counter. If clear and a hit occur in the same cycle, the hit wins.
- Asynchronous reset mid-operation returns everything to reset values immediately. The comparator then sees disabled configs and debug_resume=0.

Optional Feature:
- Macro: ORV64_MEM_BP_HIT_CNT_EN.
- Defined: CNT_W-bit saturating hit counter at index 11.
- Undefined: no counter flops; index 11 reads 0; clear bit1 affects only the hit regs and abort.

Decomposition:
- orv64_typedef_pkg gets:
  - orv64_mem_bp_state_e {IDLE=2'd0, HALTED=2'd1, RESUMING=2'd2}.
  - Register-index localparams ORV64_MEM_BP_REG_*.
  - Status bit positions.
- orv64_bp_mem_cfg_t / orv64_vaddr_t: reuse the existing definitions.
- One natural sub-module: orv64_mem_bp_regfile (cfg bus decode, addr/cfg storage, response register). The FSM and hit capture stay in the top module.

Test Plan:
- Reset, then read idx 4–7 → 0; bp_mem_cfg_* = DISABLE; debug_resume=0, bp_halt_req=0.
- Write idx0=0x8000_1000, idx4=READ, read it back → 0x8000_1000. The write response arrives 1 cycle after acceptance. With cfg_resp_ready held low for 3 cycles, cfg_req_ready stays low for those 3 cycles.
- Drive mem_bp_stall_in=1 with ex_addr=0x8000_1000, ex_re=1:
  - Next cycle bp_halt_req=1, bp_halted=1.
  - Status[1:0]=1, status[3]=1.
  - idx9=0x8000_1000; idx11=1 (feature on).
- In HALTED, write control=1 → debug_resume=1 next cycle. Hold stall 2 extra cycles; debug_resume stays 1. Drop stall → IDLE, debug_resume=0 one cycle later.
- In HALTED, drop mem_bp_stall_in with no resume → IDLE, abort=1, bp_halt_req=0. Resume and flush in the same cycle → same result.
- Preload the counter to 0xFFFF by forcing hits → it stays 0xFFFF. Clear and hit in the same cycle → counter=1 (hit wins). Assert rstn low mid-RESUMING → all outputs 0 asynchronously.
